// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI-lite IFU/LSU arbiter: FSM states, one-hot grant
// layout and response codes.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFU_RD = 2'd1,
        ST_LSU_RD = 2'd2,
        ST_LSU_WR = 2'd3
    } arb_state_e;

    localparam int GNT_W      = 3;
    localparam int GNT_IFU    = 0;
    localparam int GNT_LSU_RD = 1;
    localparam int GNT_LSU_WR = 2;
    typedef logic [GNT_W-1:0] arb_gnt_t;

    localparam int STRB_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_arb_pick.sv
// Request selector: LSU write beats LSU read; IFU wins only when it is the
// preferred master (round-robin) or nobody else is asking.
module axi_arb_pick
    import axi_arb_pkg::*;
(
    input  logic     req_ifu,
    input  logic     req_lsu_rd,
    input  logic     req_lsu_wr,
    input  logic     prefer_ifu,
    output arb_gnt_t gnt
);

    always_comb begin
        gnt = '0;
        if (prefer_ifu && req_ifu) begin
            gnt[GNT_IFU] = 1'b1;
        end else if (req_lsu_wr) begin
            gnt[GNT_LSU_WR] = 1'b1;
        end else if (req_lsu_rd) begin
            gnt[GNT_LSU_RD] = 1'b1;
        end else if (req_ifu) begin
            gnt[GNT_IFU] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_arbiter.sv
// Single-outstanding AXI-lite arbiter joining IFU reads and LSU reads/writes
// onto one memory slave. Define AXI_ARB_ROUND_ROBIN_EN for IFU/LSU round-robin.
module axi_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    output logic [1:0]        ifu_rresp,
    input  logic              ifu_rready,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    output logic [1:0]        lsu_rresp,
    input  logic              lsu_rready,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    output logic              lsu_awready,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic [1:0]        lsu_bresp,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,

    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic [1:0]        mem_rresp,
    output logic              mem_rready,
    output logic [ADDR_W-1:0] mem_awaddr,
    output logic              mem_awvalid,
    input  logic              mem_awready,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    input  logic [1:0]        mem_bresp,
    input  logic              mem_bvalid,
    output logic              mem_bready
);

    arb_state_e state, state_nx;
    arb_gnt_t   gnt;
    logic       prefer_ifu;
    // Address/data beats already accepted by the slave in the current grant;
    // they stop a master from issuing a second beat before the response.
    logic       ar_done, aw_done, w_done;

    axi_arb_pick u_pick (
        .req_ifu    (ifu_arvalid),
        .req_lsu_rd (lsu_arvalid),
        .req_lsu_wr (lsu_awvalid),
        .prefer_ifu (prefer_ifu),
        .gnt        (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                ar_done <= ar_done | (mem_arvalid & mem_arready);
                aw_done <= aw_done | (mem_awvalid & mem_awready);
                w_done  <= w_done  | (mem_wvalid  & mem_wready);
            end
        end
    end

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // After reset LSU is favoured; each grant hands preference to the other master.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prefer_ifu <= 1'b0;
        end else if (state == ST_IDLE && state_nx != ST_IDLE) begin
            prefer_ifu <= (state_nx != ST_IFU_RD);
        end
    end
`else
    assign prefer_ifu = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rvalid  = 1'b0;
        ifu_rresp   = RESP_OKAY;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rvalid  = 1'b0;
        lsu_rresp   = RESP_OKAY;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = RESP_OKAY;
        lsu_bvalid  = 1'b0;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (gnt[GNT_LSU_WR]) begin
                    state_nx = ST_LSU_WR;
                end else if (gnt[GNT_LSU_RD]) begin
                    state_nx = ST_LSU_RD;
                end else if (gnt[GNT_IFU]) begin
                    state_nx = ST_IFU_RD;
                end
            end
            ST_IFU_RD: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid & ~ar_done;
                ifu_arready = mem_arready & ~ar_done;
                ifu_rdata   = mem_rdata;
                ifu_rvalid  = mem_rvalid;
                ifu_rresp   = mem_rresp;
                mem_rready  = ifu_rready;
                if (mem_rvalid && ifu_rready) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LSU_RD: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid & ~ar_done;
                lsu_arready = mem_arready & ~ar_done;
                lsu_rdata   = mem_rdata;
                lsu_rvalid  = mem_rvalid;
                lsu_rresp   = mem_rresp;
                mem_rready  = lsu_rready;
                if (mem_rvalid && lsu_rready) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LSU_WR: begin
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid & ~aw_done;
                lsu_awready = mem_awready & ~aw_done;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid & ~w_done;
                lsu_wready  = mem_wready & ~w_done;
                lsu_bresp   = mem_bresp;
                lsu_bvalid  = mem_bvalid;
                mem_bready  = lsu_bready;
                if (mem_bvalid && lsu_bready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Self-checking bench for axi_arbiter: behavioural AXI-lite slave plus a
// response scoreboard ordered by expected grant sequence.
module tb_axi_arbiter;
    import axi_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic [AW-1:0] ifu_araddr;
    logic          ifu_arvalid, ifu_arready;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_rvalid, ifu_rready;
    logic [1:0]    ifu_rresp;

    logic [AW-1:0] lsu_araddr, lsu_awaddr;
    logic          lsu_arvalid, lsu_arready;
    logic [DW-1:0] lsu_rdata, lsu_wdata;
    logic          lsu_rvalid, lsu_rready;
    logic [1:0]    lsu_rresp, lsu_bresp;
    logic          lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [7:0]    lsu_wstrb;

    logic [AW-1:0] mem_araddr, mem_awaddr;
    logic          mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic [1:0]    mem_rresp, mem_bresp;
    logic          mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
    logic [7:0]    mem_wstrb;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          who;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Slave model controls and state.
    logic          slave_mute  = 1'b0;
    logic [1:0]    slave_rresp = RESP_OKAY;
    logic          aw_after_w  = 1'b0;
    logic          slv_rvalid, inj_rvalid;
    logic [DW-1:0] slv_rdata, inj_rdata;
    logic          aw_got, w_got;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    wr_strb;
    int            wr_count = 0;

    assign mem_rvalid  = slv_rvalid | inj_rvalid;
    assign mem_rdata   = inj_rvalid ? inj_rdata : slv_rdata;
    assign mem_arready = 1'b1;
    assign mem_wready  = 1'b1;
    assign mem_bresp   = RESP_OKAY;
    always_comb mem_awready = aw_after_w ? w_got : 1'b1;

    axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rresp(mem_rresp), .mem_rready(mem_rready),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Slave: read data one cycle after AR; B one cycle after both AW and W.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            slv_rvalid <= 1'b0;
            slv_rdata  <= '0;
            mem_rresp  <= RESP_OKAY;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            mem_bvalid <= 1'b0;
        end else begin
            if (mem_arvalid && mem_arready && !slave_mute) begin
                slv_rvalid <= 1'b1;
                slv_rdata  <= data_of(mem_araddr);
                mem_rresp  <= slave_rresp;
            end else if (slv_rvalid && mem_rready) begin
                slv_rvalid <= 1'b0;
            end
            if (mem_awvalid && mem_awready) begin
                aw_got  <= 1'b1;
                wr_addr <= mem_awaddr;
            end
            if (mem_wvalid && mem_wready) begin
                w_got   <= 1'b1;
                wr_data <= mem_wdata;
                wr_strb <= mem_wstrb;
            end
            if (aw_got && w_got && !mem_bvalid) begin
                mem_bvalid <= 1'b1;
                wr_count   <= wr_count + 1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else if (mem_bvalid && mem_bready) begin
                mem_bvalid <= 1'b0;
            end
        end
    end

    // Response monitor: every completed handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            if (ifu_rvalid && ifu_rready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_ifu: got unexpected rdata=%h, required no response", ifu_rdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.who !== 0 || mon_e.data !== ifu_rdata || mon_e.resp !== ifu_rresp) begin
                        bad++;
                        $display("FAIL sb_ifu: got ifu data=%h resp=%0d, required who=%0d data=%h resp=%0d",
                                 ifu_rdata, ifu_rresp, mon_e.who, mon_e.data, mon_e.resp);
                    end
                end
            end
            if (lsu_rvalid && lsu_rready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_lsu_rd: got unexpected rdata=%h, required no response", lsu_rdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.who !== 1 || mon_e.data !== lsu_rdata || mon_e.resp !== lsu_rresp) begin
                        bad++;
                        $display("FAIL sb_lsu_rd: got lsu data=%h resp=%0d, required who=%0d data=%h resp=%0d",
                                 lsu_rdata, lsu_rresp, mon_e.who, mon_e.data, mon_e.resp);
                    end
                end
            end
            if (lsu_bvalid && lsu_bready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_lsu_wr: got unexpected bresp=%0d, required no response", lsu_bresp);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.who !== 2 || mon_e.resp !== lsu_bresp) begin
                        bad++;
                        $display("FAIL sb_lsu_wr: got bresp=%0d, required who=%0d resp=%0d",
                                 lsu_bresp, mon_e.who, mon_e.resp);
                    end
                end
            end
        end
    end

    task automatic push(input int who, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.resp = resp;
        sb.push_back(e);
    endtask

    // who: 0 = IFU, 1 = LSU. Holds arvalid until the AR handshake.
    task automatic ar_req(input int who, input logic [31:0] addr);
        int n = 0;
        if (who == 0) begin ifu_araddr = addr; ifu_arvalid = 1'b1; end
        else          begin lsu_araddr = addr; lsu_arvalid = 1'b1; end
        forever begin
            @(negedge clk);
            if ((who == 0) ? ifu_arready : lsu_arready) break;
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("FAIL ar_timeout: master %0d got no arready, required within 60 cycles", who);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (who == 0) ifu_arvalid = 1'b0;
        else          lsu_arvalid = 1'b0;
    endtask

    // ch: 0 = W, 1 = AW.
    task automatic wr_hs(input int ch);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((ch == 0) ? lsu_wready : lsu_awready) break;
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("FAIL wr_timeout: channel %0d got no ready, required within 60 cycles", ch);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (ch == 0) lsu_wvalid = 1'b0;
        else         lsu_awvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending responses, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifu_araddr = 32'hFFFF_FFFF; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        lsu_araddr = 32'hFFFF_FFFF; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        lsu_awaddr = 32'hFFFF_FFFF; lsu_awvalid = 1'b1; lsu_bready = 1'b1;
        lsu_wdata  = 32'hFFFF_FFFF; lsu_wstrb = 8'hFF; lsu_wvalid = 1'b1;
        inj_rvalid = 1'b1; inj_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        total++;
        if ({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_master_hs: got %b, required 0",
                     {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid});
        end
        total++;
        if ({mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mem_hs: got %b, required 0",
                     {mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready});
        end
        total++;
        if ({ifu_rdata, ifu_rresp, lsu_rdata, lsu_rresp, lsu_bresp} !== '0 ||
            {mem_araddr, mem_awaddr, mem_wdata, mem_wstrb} !== '0) begin
            bad++;
            $display("FAIL reset_data: got ifu_rdata=%h lsu_rdata=%h mem_araddr=%h mem_wdata=%h, required 0",
                     ifu_rdata, lsu_rdata, mem_araddr, mem_wdata);
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        lsu_wstrb = 8'h00; inj_rvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (mem_arvalid !== 1'b0 || mem_rready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got mem_arvalid=%b mem_rready=%b, required 0", mem_arvalid, mem_rready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ifu_read();
        push(0, 32'h0000_0413, RESP_OKAY);
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        @(negedge clk);
        total++;
        if (mem_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL ifu_lat0: got mem_arvalid=%b, required 0 in request cycle", mem_arvalid);
        end
        @(negedge clk);
        total++;
        if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin
            bad++;
            $display("FAIL ifu_lat1: got mem_arvalid=%b araddr=%h, required 1 and 80000000", mem_arvalid, mem_araddr);
        end
        @(posedge clk);
        #1 ifu_arvalid = 1'b0;
        @(negedge clk);
        total++;
        if (ifu_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL ifu_rlat: got ifu_rvalid=%b, required 1 with mem_rvalid", ifu_rvalid);
        end
        drain();
    endtask

    task automatic test_contention();
        push(1, data_of(32'h8000_1000), RESP_OKAY);
        push(0, data_of(32'h8000_0040), RESP_OKAY);
        fork
            ar_req(0, 32'h8000_0040);
            ar_req(1, 32'h8000_1000);
        join
        drain();
    endtask

    task automatic test_back_to_back();
`ifdef AXI_ARB_ROUND_ROBIN_EN
        push(1, data_of(32'h8000_1100), RESP_OKAY);
        push(0, data_of(32'h8000_0100), RESP_OKAY);
        push(1, data_of(32'h8000_1104), RESP_OKAY);
        push(0, data_of(32'h8000_0104), RESP_OKAY);
`else
        push(1, data_of(32'h8000_1100), RESP_OKAY);
        push(1, data_of(32'h8000_1104), RESP_OKAY);
        push(0, data_of(32'h8000_0100), RESP_OKAY);
        push(0, data_of(32'h8000_0104), RESP_OKAY);
`endif
        fork
            begin ar_req(0, 32'h8000_0100); ar_req(0, 32'h8000_0104); end
            begin ar_req(1, 32'h8000_1100); ar_req(1, 32'h8000_1104); end
        join
        drain();
    endtask

    task automatic test_write();
        int cnt0;
        cnt0 = wr_count;
        aw_after_w = 1'b1;
        push(2, 32'h0, RESP_OKAY);
        lsu_wdata  = 32'hDEAD_BEEF;
        lsu_wstrb  = 8'h0F;
        lsu_wvalid = 1'b1;
        @(posedge clk);
        #1;
        lsu_awaddr  = 32'h8000_2000;
        lsu_awvalid = 1'b1;
        fork
            wr_hs(0);
            wr_hs(1);
        join
        drain();
        total++;
        if (wr_count - cnt0 !== 1 || wr_addr !== 32'h8000_2000 || wr_data !== 32'hDEAD_BEEF || wr_strb !== 8'h0F) begin
            bad++;
            $display("FAIL write_mem: got count=%0d addr=%h data=%h strb=%h, required 1 80002000 deadbeef 0f",
                     wr_count - cnt0, wr_addr, wr_data, wr_strb);
        end
        @(negedge clk);
        total++;
        if (mem_bready !== 1'b0 || lsu_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL write_idle: got mem_bready=%b lsu_bvalid=%b, required 0", mem_bready, lsu_bvalid);
        end
        aw_after_w = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_error();
        slave_rresp = RESP_SLVERR;
        push(1, data_of(32'h8000_3000), RESP_SLVERR);
        ar_req(1, 32'h8000_3000);
        drain();
        slave_rresp = RESP_OKAY;
        push(0, data_of(32'h8000_0200), RESP_OKAY);
        ar_req(0, 32'h8000_0200);
        drain();
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        slave_mute  = 1'b1;
        ifu_araddr  = 32'h8000_0300;
        ifu_arvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_arvalid) break;
            n++;
            if (n > 10) begin
                total++;
                bad++;
                $display("FAIL rst_mid_grant: got no mem_arvalid, required within 10 cycles");
                break;
            end
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({mem_arvalid, ifu_arready, ifu_rvalid, mem_rready} !== 4'b0 || mem_araddr !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got hs=%b araddr=%h, required 0",
                     {mem_arvalid, ifu_arready, ifu_rvalid, mem_rready}, mem_araddr);
        end
        ifu_arvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        inj_rdata  = 32'h1234_5678;
        inj_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL rst_late_r: got ifu_rvalid=%b lsu_rvalid=%b, required 0", ifu_rvalid, lsu_rvalid);
            end
        end
        inj_rvalid = 1'b0;
        slave_mute = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_contention();
        test_back_to_back();
        test_write();
        test_error();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 SHALL have parameter DATA_W, default 32, data width of R/W channels; wstrb width is 8.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have IFU read port ifu_araddr/arvalid (in, ADDR_W/1), ifu_arready (out, 1): IFU address request.
REQ-006 SHALL have ifu_rdata/rvalid/rresp (out, DATA_W/1/2), ifu_rready (in, 1): IFU read return.
REQ-007 SHALL have LSU read port lsu_araddr/arvalid/arready and lsu_rdata/rvalid/rresp/rready, same widths and directions as IFU.
REQ-008 SHALL have LSU write port lsu_awaddr/awvalid, lsu_wdata/wstrb/wvalid, lsu_bready (in), and lsu_awready/wready/bresp/bvalid (out).
REQ-009 SHALL have memory-side master port mem_* mirroring all LSU signals with directions reversed, driving one AXI-lite memory slave.

Function
REQ-010 SHALL implement FSM states IDLE, IFU_RD, LSU_RD, LSU_WR; exactly one state at a time.
REQ-011 SHALL, in IDLE, sample requests (ifu_arvalid, lsu_arvalid, lsu_awvalid) and move to the selected grant state on the next edge; no channel is connected in IDLE.
REQ-012 SHALL, without round-robin, select fixed priority LSU_WR > LSU_RD > IFU_RD.
REQ-013 SHALL, in a grant state, connect the granted master's channels combinationally to mem_*; the slave's ready/valid/data/resp pass through unmodified.
REQ-014 SHALL hold every ready and valid output toward a non-granted master at 0, and drive mem_* valids to 0 for ungranted channels.
REQ-015 SHALL leave IFU_RD/LSU_RD for IDLE on the edge where mem_rvalid & granted rready are both 1.
REQ-016 SHALL leave LSU_WR for IDLE on the edge where mem_bvalid & lsu_bready are both 1; AW and W may complete in either order or together.
REQ-017 SHALL add exactly one cycle of arbitration latency (request to mem_*valid asserted) and zero cycles on data return.
REQ-018 SHALL NOT change grant while a transaction is outstanding; new requests arriving mid-transaction wait in their valid.
REQ-019 SHALL pass rresp/bresp error codes to the granted master unchanged, with no retry.

Reset
REQ-020 SHALL, on rst low, immediately force IDLE and drive all ready/valid outputs to 0, and all data/resp outputs to 0.
REQ-021 SHALL, on reset mid-transaction, abandon the outstanding slave transaction; no completion is forwarded after reset release.
REQ-022 SHALL reset the round-robin pointer to favour LSU.

Configuration
REQ-023 SHALL, with macro AXI_ARB_ROUND_ROBIN_EN defined, arbitrate IFU vs LSU round-robin: the master not granted last wins contention; LSU write still beats LSU read.
REQ-024 SHALL, without AXI_ARB_ROUND_ROBIN_EN, use fixed priority per REQ-012 and contain no pointer register.

Structure
REQ-025 SHALL take the FSM state enum, grant encoding and AXI resp codes (OKAY=0, SLVERR=2) from shared package axi_arb_pkg.
REQ-026 SHALL place the request-selection logic in sub-module axi_arb_pick (requests plus pointer in, one-hot grant out).

Verification
REQ-027 IFU-only: ifu_araddr=0x80000000, slave returns 0x00000413 -> ifu_rvalid with rdata 0x00000413, mem_arvalid one cycle after ifu_arvalid.
REQ-028 Contention, fixed priority: ifu and lsu arvalid in same cycle, lsu_araddr=0x80001000 -> LSU served first, IFU next after LSU R handshake.
REQ-029 Write: lsu_awaddr=0x80002000, wdata=0xDEADBEEF, wstrb=0x0F, W before AW -> single mem write, lsu_bvalid with bresp=0, then IDLE.
REQ-030 Round-robin enabled: IFU and LSU both request continuously for 4 transactions -> grants alternate LSU, IFU, LSU, IFU.
REQ-031 Reset mid-read: rst low while in IFU_RD -> all valids 0 same cycle; after release, a late mem_rvalid is not forwarded.
REQ-032 Error: slave returns rresp=2 on LSU read -> lsu_rresp=2, FSM returns to IDLE normally.
